// File: rtl/ariane_pkg.sv
// Shared core types: the scoreboard entry carried from decode to issue, plus
// the sizing constants for the decoded-instruction queue.
package ariane_pkg;

  localparam int unsigned DEC_QUEUE_DEPTH         = 4;
  localparam int unsigned MAX_UNRESOLVED_BRANCHES = 1;

  typedef enum logic [2:0] {
    FU_NONE,
    FU_ALU,
    FU_BRANCH,
    FU_LOAD,
    FU_STORE,
    FU_MULT,
    FU_CSR
  } fu_t;

  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } scoreboard_entry_t;

endpackage

// File: rtl/decoded_instr_queue.sv
// Registered FIFO of decoded instructions between decode and issue. It also
// holds a control-flow head back while too many branches are unresolved.
module decoded_instr_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH          = DEC_QUEUE_DEPTH,
  parameter int unsigned MAX_UNRESOLVED = MAX_UNRESOLVED_BRANCHES
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic                                  flush_unissued_instr_i,
  input  scoreboard_entry_t                     decoded_instr_i,
  input  logic                                  decoded_instr_valid_i,
  input  logic                                  is_ctrl_flow_i,
  output logic                                  decoded_instr_ack_o,
  output scoreboard_entry_t                     issue_instr_o,
  output logic                                  issue_instr_valid_o,
  output logic                                  is_ctrl_flow_o,
  input  logic                                  issue_ack_i,
  input  logic                                  resolve_branch_i,
  output logic                                  full_o,
  output logic [$clog2(DEPTH+1)-1:0]            count_o,
  output logic [$clog2(MAX_UNRESOLVED+1)-1:0]   unresolved_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int UNR_W = $clog2(MAX_UNRESOLVED + 1);

  scoreboard_entry_t mem_q  [DEPTH];
  logic              ctrl_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [UNR_W-1:0] unresolved_q, unresolved_d;

  logic push, pop, head_ctrl, at_limit, br_inc, br_dec;

  assign head_ctrl = ctrl_q[rd_ptr_q];
  assign at_limit  = (unresolved_q == UNR_W'(MAX_UNRESOLVED));

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign count_o      = count_q;
  assign unresolved_o = unresolved_q;

  // Ack looks only at the offer, flushes and registered state, so issue
  // back-pressure never reaches decode combinationally.
  assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i
                             & ~flush_unissued_instr_i & ~rst_i;
  assign push = decoded_instr_ack_o;

  assign issue_instr_o       = mem_q[rd_ptr_q];
  assign is_ctrl_flow_o      = head_ctrl;
  assign issue_instr_valid_o = (count_q != '0) & ~(head_ctrl & at_limit);
  assign pop                 = issue_ack_i & issue_instr_valid_o;

  assign br_inc = pop & head_ctrl;
  assign br_dec = resolve_branch_i & (unresolved_q != '0);

  // NOTE: storage carries no reset; only pointers and counters define which
  // entries are live, so resetting the array would buy nothing.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q]  <= decoded_instr_i;
      ctrl_q[wr_ptr_q] <= is_ctrl_flow_i;
    end
  end

  // NOTE: every next-state variable gets a default at the top of the block so
  // no path through the branches below can infer a latch.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    unresolved_d = unresolved_q;

    if (flush_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      unresolved_d = '0;
    end else if (flush_unissued_instr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if (br_dec) unresolved_d = unresolved_q - UNR_W'(1);
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      unique case ({br_inc, br_dec})
        2'b10:   unresolved_d = unresolved_q + UNR_W'(1);
        2'b01:   unresolved_d = unresolved_q - UNR_W'(1);
        default: unresolved_d = unresolved_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      unresolved_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      unresolved_q <= unresolved_d;
    end
  end

  // Execute must never resolve more branches than were issued, and the head
  // gate must keep a control-flow pop from exceeding the limit.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   !(resolve_branch_i && unresolved_q == '0))
    else $error("resolve_branch_i with no outstanding branch");

  assert property (@(posedge clk_i) disable iff (rst_i)
                   !(pop && head_ctrl && at_limit))
    else $error("control-flow pop at unresolved limit");

endmodule

// File: tb/tb_decoded_instr_queue.sv
// Directed bench for decoded_instr_queue; a scoreboard queue holds the
// expected issue order and a negedge monitor compares every pop.
module tb_decoded_instr_queue;
  import ariane_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, default sizing (DEPTH 4, MAX_UNRESOLVED 1)
  logic              rst, flush, flush_un, din_valid, din_ctrl, ack;
  scoreboard_entry_t din, dout;
  logic              dout_valid, dout_ctrl, issue_ack, resolve, full;
  logic [2:0]        count;
  logic [0:0]        unresolved;

  decoded_instr_queue u_dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .flush_i                (flush),
    .flush_unissued_instr_i (flush_un),
    .decoded_instr_i        (din),
    .decoded_instr_valid_i  (din_valid),
    .is_ctrl_flow_i         (din_ctrl),
    .decoded_instr_ack_o    (ack),
    .issue_instr_o          (dout),
    .issue_instr_valid_o    (dout_valid),
    .is_ctrl_flow_o         (dout_ctrl),
    .issue_ack_i            (issue_ack),
    .resolve_branch_i       (resolve),
    .full_o                 (full),
    .count_o                (count),
    .unresolved_o           (unresolved)
  );

  // Second instance allowing two unresolved branches, for pop+resolve overlap
  logic              b_rst, b_din_valid, b_din_ctrl, b_ack;
  scoreboard_entry_t b_din, b_dout;
  logic              b_dout_valid, b_dout_ctrl, b_issue_ack, b_resolve, b_full;
  logic [2:0]        b_count;
  logic [1:0]        b_unresolved;

  decoded_instr_queue #(.DEPTH(4), .MAX_UNRESOLVED(2)) u_dut2 (
    .clk_i                  (clk),
    .rst_i                  (b_rst),
    .flush_i                (1'b0),
    .flush_unissued_instr_i (1'b0),
    .decoded_instr_i        (b_din),
    .decoded_instr_valid_i  (b_din_valid),
    .is_ctrl_flow_i         (b_din_ctrl),
    .decoded_instr_ack_o    (b_ack),
    .issue_instr_o          (b_dout),
    .issue_instr_valid_o    (b_dout_valid),
    .is_ctrl_flow_o         (b_dout_ctrl),
    .issue_ack_i            (b_issue_ack),
    .resolve_branch_i       (b_resolve),
    .full_o                 (b_full),
    .count_o                (b_count),
    .unresolved_o           (b_unresolved)
  );

  typedef struct {
    scoreboard_entry_t entry;
    logic              ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic scoreboard_entry_t mk(input int id, input logic br);
    scoreboard_entry_t e;
    e.pc  = 32'h1000 + 32'(id) * 4;
    e.fu  = br ? FU_BRANCH : FU_ALU;
    e.rd  = 5'(id);
    e.rs1 = 5'(id + 1);
    e.rs2 = 5'(id + 2);
    e.imm = 32'(id) * 7;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  // Drive one offer to the main instance and, if an ack is expected, record it
  task automatic offer(input int id, input logic br);
    exp_t e;
    din_valid = 1'b1;
    din       = mk(id, br);
    din_ctrl  = br;
    e.entry   = mk(id, br);
    e.ctrl    = br;
    exp_q.push_back(e);
  endtask

  // Monitor: whenever the main instance pops, compare against the scoreboard
  always @(negedge clk) begin
    if (!rst && !flush && !flush_un && dout_valid && issue_ack) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got pc 0x%0h expected no pop at %0t", dout.pc, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_pc",   dout.pc,        e.entry.pc);
        check("pop_imm",  dout.imm,       e.entry.imm);
        check("pop_fu",   32'(dout.fu),   32'(e.entry.fu));
        check("pop_ctrl", 32'(dout_ctrl), 32'(e.ctrl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; flush_un = 1'b0;
    din = mk(0, 1'b0); din_valid = 1'b1; din_ctrl = 1'b0;
    issue_ack = 1'b0; resolve = 1'b0;
    b_rst = 1'b1; b_din = mk(0, 1'b0); b_din_valid = 1'b0; b_din_ctrl = 1'b0;
    b_issue_ack = 1'b0; b_resolve = 1'b0;

    // Reset: ack held low while reset is asserted even with a valid offer
    #1;
    half();
    check("rst_ack_held", 32'(ack), 0);
    tick();
    rst = 1'b0; din_valid = 1'b0;
    half();
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_full", 32'(full), 0);
    check("rst_unres", 32'(unresolved), 0);
    tick();

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      offer(i, 1'b0);
      half();
      check("fill_count", 32'(count), 32'(i));
      check("fill_ack", 32'(ack), 1);
      tick();
    end
    din_valid = 1'b1; din = mk(99, 1'b0); din_ctrl = 1'b0;
    half();
    check("full_flag", 32'(full), 1);
    check("full_count", 32'(count), 4);
    check("full_ack", 32'(ack), 0);
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_ack = 1'b1;
      // Offer while full with a same-cycle pop: still refused
      if (i == 0) begin
        din_valid = 1'b1;
        half();
        check("full_pop_ack", 32'(ack), 0);
      end else begin
        half();
      end
      check("drain_valid", 32'(dout_valid), 1);
      tick();
      din_valid = 1'b0;
    end
    issue_ack = 1'b0;
    half();
    check("drain_count", 32'(count), 0);
    check("drain_valid_end", 32'(dout_valid), 0);
    tick();

    // Streaming: push and pop every cycle, pointers wrap several times
    issue_ack = 1'b1;
    for (int k = 0; k < 20; k++) begin
      offer(100 + k, 1'b0);
      half();
      check("stream_ack", 32'(ack), 1);
      check("stream_valid", 32'(dout_valid), (k == 0) ? 0 : 1);
      check("stream_count", 32'(count), (k == 0) ? 0 : 1);
      tick();
    end
    din_valid = 1'b0;
    half();
    check("stream_last_valid", 32'(dout_valid), 1);
    tick();
    issue_ack = 1'b0;
    half();
    check("stream_end_count", 32'(count), 0);
    tick();

    // Branch gating: BR1, BR2, ALU
    issue_ack = 1'b0;
    offer(200, 1'b1); tick();
    offer(201, 1'b1); tick();
    offer(202, 1'b0); tick();
    din_valid = 1'b0;
    issue_ack = 1'b1;
    half();
    check("br1_valid", 32'(dout_valid), 1);
    check("br1_ctrl", 32'(dout_ctrl), 1);
    check("br1_unres", 32'(unresolved), 0);
    tick();
    half();
    check("br2_held_unres", 32'(unresolved), 1);
    check("br2_held_valid", 32'(dout_valid), 0);
    check("br2_held_ctrl", 32'(dout_ctrl), 1);
    check("br2_held_count", 32'(count), 2);
    tick();
    issue_ack = 1'b0; resolve = 1'b1;
    half();
    check("resolve_cycle_valid", 32'(dout_valid), 0);
    tick();
    resolve = 1'b0;
    half();
    check("br2_release_unres", 32'(unresolved), 0);
    check("br2_release_valid", 32'(dout_valid), 1);
    tick();

    // Same-cycle pop and resolve on the two-branch instance
    b_rst = 1'b0;
    b_din_valid = 1'b1; b_din = mk(300, 1'b1); b_din_ctrl = 1'b1;
    half();
    check("b_push_ack", 32'(b_ack), 1);
    tick();
    b_din = mk(301, 1'b1); b_issue_ack = 1'b1;
    half();
    check("b_pop1_valid", 32'(b_dout_valid), 1);
    check("b_pop1_pc", b_dout.pc, mk(300, 1'b1).pc);
    tick();
    b_din_valid = 1'b0; b_resolve = 1'b1;
    half();
    check("b_pop2_valid", 32'(b_dout_valid), 1);
    check("b_pop2_pc", b_dout.pc, mk(301, 1'b1).pc);
    check("b_pre_unres", 32'(b_unresolved), 1);
    tick();
    b_issue_ack = 1'b0; b_resolve = 1'b0;
    half();
    check("b_overlap_unres", 32'(b_unresolved), 1);
    check("b_overlap_count", 32'(b_count), 0);
    tick();
    b_resolve = 1'b1;
    tick();
    b_resolve = 1'b0;
    half();
    check("b_final_unres", 32'(b_unresolved), 0);
    tick();

    // Flushes: main queue holds BR2, ALU; pop BR2 while pushing, then push again
    issue_ack = 1'b1;
    offer(210, 1'b0);
    tick();
    issue_ack = 1'b0;
    offer(211, 1'b0);
    tick();
    din_valid = 1'b0;
    half();
    check("pre_flush_count", 32'(count), 3);
    check("pre_flush_unres", 32'(unresolved), 1);
    tick();
    flush_un = 1'b1; din_valid = 1'b1; din = mk(220, 1'b0); din_ctrl = 1'b0;
    exp_q.delete();
    half();
    check("flush_un_ack", 32'(ack), 0);
    tick();
    flush_un = 1'b0; din_valid = 1'b0;
    half();
    check("flush_un_count", 32'(count), 0);
    check("flush_un_valid", 32'(dout_valid), 0);
    check("flush_un_unres", 32'(unresolved), 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    half();
    check("flush_unres", 32'(unresolved), 0);
    check("flush_count", 32'(count), 0);
    tick();

    // Reset mid-stream: two queued, a push pending
    offer(400, 1'b0); tick();
    offer(401, 1'b0); tick();
    rst = 1'b1; din = mk(402, 1'b0);
    exp_q.delete();
    half();
    check("midrst_ack", 32'(ack), 0);
    tick();
    half();
    check("midrst_valid", 32'(dout_valid), 0);
    check("midrst_count", 32'(count), 0);
    check("midrst_full", 32'(full), 0);
    check("midrst_ack_held", 32'(ack), 0);
    tick();
    rst = 1'b0; din_valid = 1'b0;
    tick();

    // Queue works again after reset
    offer(500, 1'b0);
    tick();
    din_valid = 1'b0; issue_ack = 1'b1;
    half();
    check("post_rst_valid", 32'(dout_valid), 1);
    tick();
    issue_ack = 1'b0;
    half();
    check("post_rst_count", 32'(count), 0);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoded_instr_queue.md
# decoded_instr_queue

Buffers decoded instructions between the decode stage and the issue stage, decoupling the decoder's valid/ack handshake from issue back-pressure. The queue is a registered FIFO of `scoreboard_entry_t`. It also limits the number of unresolved control-flow instructions in flight: a control-flow instruction at the head is held back while the outstanding-branch count is at its limit, and each `resolve_branch_i` from execute releases one slot.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `MAX_UNRESOLVED`, 1: maximum issued-but-unresolved control-flow instructions; ≥1.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset; synchronous and active-high.
- `flush_i` in 1: full flush; empties the queue and clears the outstanding-branch count.
- `flush_unissued_instr_i` in 1: empties the queue; keeps the outstanding-branch count.
- `decoded_instr_i` in `scoreboard_entry_t`: instruction from decode.
- `decoded_instr_valid_i` in 1: decode offers an instruction.
- `is_ctrl_flow_i` in 1: the offered instruction is a branch or jump.
- `decoded_instr_ack_o` out 1: the instruction is accepted this cycle.
- `issue_instr_o` out `scoreboard_entry_t`: head entry.
- `issue_instr_valid_o` out 1: head entry may be issued.
- `is_ctrl_flow_o` out 1: head entry is control flow.
- `issue_ack_i` in 1: issue consumes the head.
- `resolve_branch_i` in 1: execute resolved one control-flow instruction.
- `full_o` out 1: queue holds `DEPTH` entries.
- `count_o` out `$clog2(DEPTH+1)`: current occupancy.
- `unresolved_o` out `$clog2(MAX_UNRESOLVED+1)`: outstanding-branch count.

## Operation
- **Storage.** Circular buffer with read and write pointers of width `$clog2(DEPTH)`; pointers wrap naturally. A separate occupancy counter distinguishes full from empty.
- **Push.** `decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i & ~flush_unissued_instr_i`.
  - On ack, `decoded_instr_i` and `is_ctrl_flow_i` are written at the write pointer, which then increments.
- **Head gating.** `issue_instr_valid_o = (count_o != 0) & ~(is_ctrl_flow_o & (unresolved_o == MAX_UNRESOLVED))`.
- **Pop.** When `issue_ack_i & issue_instr_valid_o`, the read pointer increments.
  - `issue_ack_i` while `issue_instr_valid_o` is low is ignored.
- **Branch counter.**
  - Increments on a pop of a control-flow entry.
  - Decrements on `resolve_branch_i`.
  - If both occur in the same cycle, the count is unchanged.
  - `resolve_branch_i` at count 0 is ignored and flagged by an assertion.
  - A control-flow pop at `MAX_UNRESOLVED` cannot occur, because the head is gated.
- **Flushes.**
  - `flush_i`: pointers and occupancy go to 0, and `unresolved_o` goes to 0.
  - `flush_unissued_instr_i`: pointers and occupancy go to 0; `unresolved_o` still applies `resolve_branch_i`.
  - A flush takes priority over a same-cycle push and pop.
- **Full queue.** A push is refused even if a pop happens in the same cycle; `decoded_instr_ack_o` does not depend on `issue_ack_i`.
- **Output values.** `issue_instr_o` and `is_ctrl_flow_o` are valid only while `issue_instr_valid_o` is high. When the queue is empty they show the stale storage contents.

## Timing
- **Latency.** First-word latency is 1 cycle: an instruction accepted at edge N appears with `issue_instr_valid_o = 1` after edge N.
- **Throughput.** One push and one pop per cycle when not full.
- **Combinational paths.** None from `decoded_instr_valid_i` to `issue_instr_valid_o`, and none from `issue_ack_i` to `decoded_instr_ack_o`.
  - `decoded_instr_ack_o` depends only on `decoded_instr_valid_i`, the flushes and registered state.
  - `issue_instr_valid_o` depends only on registered state.
- **Reset.** `rst_i` is sampled at the rising edge. Afterwards:
  - pointers, occupancy and `unresolved_o` are 0;
  - `issue_instr_valid_o`, `full_o` and `decoded_instr_ack_o` are 0, with `decoded_instr_ack_o` held at 0 while `rst_i` is asserted;
  - storage is not reset.
- **Reset mid-operation.** Reset overrides all other events in that cycle.

## Structure
- **Shared types.** `scoreboard_entry_t` comes from `ariane_pkg`.
- **Package additions.** None required. `DEPTH` and `MAX_UNRESOLVED` are defaulted from new `ariane_pkg` constants `DEC_QUEUE_DEPTH` and `MAX_UNRESOLVED_BRANCHES`.
- **Sub-modules.** None. Storage, pointers and the branch counter fit in a single module.
- **Integration.** Instantiated between the decode stage and the issue stage's rename input. Its `resolve_branch_i` is driven from the same execute-stage signal the issue stage receives.

## Test plan
- **Fill and drain.** Push 4 ALU entries with `issue_ack_i` low.
  - `full_o = 1`, `count_o = 4`, fifth valid gets ack 0.
  - Then ack 4 times: entries emerge in order, `count_o` returns to 0.
- **Streaming.** Push and pop every cycle for 20 cycles with the pointers wrapping.
  - `count_o` stays 1 and order is preserved.
  - Valid rises exactly 1 cycle after the first push.
- **Branch gating (`MAX_UNRESOLVED = 1`).** Push BR1, BR2, ALU.
  - Pop BR1, then `unresolved_o = 1` and BR2 is held with valid 0.
  - Assert `resolve_branch_i` for 1 cycle: BR2 is valid the next cycle.
- **Same-cycle pop and resolve.** A control-flow pop coincides with `resolve_branch_i` at count 1 → `unresolved_o` stays 1.
- **Flushes.** Queue holds 3 entries and `unresolved_o = 1`.
  - `flush_unissued_instr_i` with a same-cycle valid push: count 0, ack 0, `unresolved_o = 1`.
  - Then `flush_i`: `unresolved_o = 0`.
- **Reset mid-stream.** Assert `rst_i` with 2 entries queued and a push pending.
  - Next cycle: `issue_instr_valid_o = 0`, `count_o = 0`, `full_o = 0`.
  - `decoded_instr_ack_o = 0` while `rst_i` is held.
